// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serializes a WIDTH-bit word LSB first into a downstream
// right-shift register, then idles GAP_CYCLES cycles and pulses done.
// Ports: clk, rst_n (async, active-low), in_data/in_valid/in_ready (word
// handshake), abort (cancel word in flight), ser_a/shift_en (to the shift
// register), busy (state != IDLE), done (one-cycle end-of-word pulse).
module shift_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_a,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] BIT_LAST =
    CW'(WIDTH - 1);

  localparam logic [3:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]   bit_cnt;
  logic [3:0]      gap_cnt;

  assign in_ready = (state == IDLE) && !abort;

  // Outputs are registered, so ser_a is loaded one bit ahead of the
  // shift: bit 0 on acceptance, then hold[1] of the not-yet-shifted hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ser_a    <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            hold     <= in_data;
            bit_cnt  <= '0;
            ser_a    <= in_data[0];
            shift_en <= 1'b1;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state    <= IDLE;
            ser_a    <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            hold    <= hold >> 1;
            if (bit_cnt == BIT_LAST) begin
              ser_a    <= 1'b0;
              shift_en <= 1'b0;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              ser_a <= hold[1];
            end
          end
        end
        GAP: begin
          if (abort) begin
            state    <= IDLE;
            ser_a    <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
            if (gap_cnt == GAP_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
